block_scan_ctrl: RTL and testbench

- Frame-level sequencer for the 8x8 block compression datapath.
- On a start pulse it walks a raster image one 8x8 tile at a time and issues frame-buffer read addresses over a valid/ready handshake to the DCT input stage.
- Within each tile the order is pixel raster. Tiles are visited in raster order.
- Per-beat tags (tile index, first/last pixel of a tile, last pixel of the frame) and busy/done status are provided for the top-level controller.

---
 rtl/block_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_block_scan_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/block_scan_ctrl.sv
// Frame sequencer for the 8x8 block datapath. It walks the image one tile at a
// time, in raster order within each tile and in raster order of tiles, and
// issues pixel read addresses plus per-beat tags over a valid/ready handshake.
module block_scan_ctrl #(
    parameter int unsigned IMG_W_BLK = 8,
    parameter int unsigned IMG_H_BLK = 8,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BLK_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_addr_valid,
    input  logic              i_addr_ready,
    output logic [BLK_W-1:0]  o_blk_idx,
    output logic              o_blk_first,
    output logic              o_blk_last,
    output logic              o_frame_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned IMG_W = 8 * IMG_W_BLK;
    localparam logic [BLK_W-1:0] LAST_BCOL = BLK_W'(IMG_W_BLK - 1);
    localparam logic [BLK_W-1:0] LAST_BROW = BLK_W'(IMG_H_BLK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Counters describe the beat currently presented on the output registers.
    logic [2:0]        r_px, r_py;
    logic [BLK_W-1:0]  r_bcol, r_brow;
    logic [2:0]        w_px_adv, w_py_adv, w_px_nxt, w_py_nxt;
    logic [BLK_W-1:0]  w_bcol_adv, w_brow_adv, w_bcol_nxt, w_brow_nxt;

    logic              w_xfer;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [BLK_W-1:0]  w_blk_idx_nxt;
    logic              w_blk_first_nxt, w_blk_last_nxt, w_frame_last_nxt;
    logic              w_done_nxt;

    assign w_xfer = o_addr_valid & i_addr_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_xfer && o_frame_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Counter advance by compare-to-limit so non-power-of-two widths wrap correctly.
    always_comb begin
        w_px_adv   = r_px;
        w_py_adv   = r_py;
        w_bcol_adv = r_bcol;
        w_brow_adv = r_brow;
        if (r_px == 3'd7) begin
            w_px_adv = 3'd0;
            if (r_py == 3'd7) begin
                w_py_adv = 3'd0;
                if (r_bcol == LAST_BCOL) begin
                    w_bcol_adv = '0;
                    w_brow_adv = r_brow + BLK_W'(1);
                end else begin
                    w_bcol_adv = r_bcol + BLK_W'(1);
                end
            end else begin
                w_py_adv = r_py + 3'd1;
            end
        end else begin
            w_px_adv = r_px + 3'd1;
        end
    end

    // Output logic: next counters and the registered beat derived from them.
    always_comb begin
        w_px_nxt   = 3'd0;
        w_py_nxt   = 3'd0;
        w_bcol_nxt = '0;
        w_brow_nxt = '0;
        if (r_state == S_RUN && w_state_nxt == S_RUN) begin
            if (w_xfer) begin
                w_px_nxt   = w_px_adv;
                w_py_nxt   = w_py_adv;
                w_bcol_nxt = w_bcol_adv;
                w_brow_nxt = w_brow_adv;
            end else begin
                w_px_nxt   = r_px;
                w_py_nxt   = r_py;
                w_bcol_nxt = r_bcol;
                w_brow_nxt = r_brow;
            end
        end

        w_valid_nxt      = (w_state_nxt == S_RUN);
        w_addr_nxt       = '0;
        w_blk_idx_nxt    = '0;
        w_blk_first_nxt  = 1'b0;
        w_blk_last_nxt   = 1'b0;
        w_frame_last_nxt = 1'b0;
        if (w_valid_nxt) begin
            w_addr_nxt       = ADDR_W'(ADDR_W'({w_brow_nxt, w_py_nxt}) * ADDR_W'(IMG_W)
                                       + ADDR_W'({w_bcol_nxt, w_px_nxt}));
            w_blk_idx_nxt    = BLK_W'(w_brow_nxt * BLK_W'(IMG_W_BLK) + w_bcol_nxt);
            w_blk_first_nxt  = (w_px_nxt == 3'd0) && (w_py_nxt == 3'd0);
            w_blk_last_nxt   = (w_px_nxt == 3'd7) && (w_py_nxt == 3'd7);
            w_frame_last_nxt = w_blk_last_nxt && (w_bcol_nxt == LAST_BCOL)
                               && (w_brow_nxt == LAST_BROW);
        end
        w_done_nxt = (r_state == S_DONE) && !i_abort;
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_px         <= 3'd0;
            r_py         <= 3'd0;
            r_bcol       <= '0;
            r_brow       <= '0;
            o_addr       <= '0;
            o_addr_valid <= 1'b0;
            o_blk_idx    <= '0;
            o_blk_first  <= 1'b0;
            o_blk_last   <= 1'b0;
            o_frame_last <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            r_px         <= w_px_nxt;
            r_py         <= w_py_nxt;
            r_bcol       <= w_bcol_nxt;
            r_brow       <= w_brow_nxt;
            o_addr       <= w_addr_nxt;
            o_addr_valid <= w_valid_nxt;
            o_blk_idx    <= w_blk_idx_nxt;
            o_blk_first  <= w_blk_first_nxt;
            o_blk_last   <= w_blk_last_nxt;
            o_frame_last <= w_frame_last_nxt;
            o_busy       <= w_valid_nxt;
            o_done       <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_block_scan_ctrl.sv
// Bench for block_scan_ctrl: a 2x2-tile instance and a 3x1-tile instance,
// checked every cycle against a beat-index model of the scan order.
module tb_block_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_start, s_abort, s_ready, s_sel;
    logic        start_a, start_b;

    logic [11:0] a_addr, b_addr;
    logic [5:0]  a_idx, b_idx;
    logic        a_valid, a_first, a_last, a_fl, a_busy, a_done;
    logic        b_valid, b_first, b_last, b_fl, b_busy, b_done;
    logic [23:0] obs_a, obs_b;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [23:0] IDLE_MASK = 24'hC40000;
    localparam logic [23:0] IDLE_EXP  = 24'h000000;
    localparam logic [23:0] DONE_EXP  = 24'h040000;

    always #5 clk = ~clk;

    assign start_a = s_start & ~s_sel;
    assign start_b = s_start & s_sel;
    assign obs_a = {a_valid, a_busy, a_first, a_last, a_fl, a_done, a_idx, a_addr};
    assign obs_b = {b_valid, b_busy, b_first, b_last, b_fl, b_done, b_idx, b_addr};

    block_scan_ctrl #(.IMG_W_BLK(2), .IMG_H_BLK(2), .ADDR_W(12), .BLK_W(6)) u_dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_abort(s_abort),
        .o_addr(a_addr), .o_addr_valid(a_valid), .i_addr_ready(s_ready),
        .o_blk_idx(a_idx), .o_blk_first(a_first), .o_blk_last(a_last),
        .o_frame_last(a_fl), .o_busy(a_busy), .o_done(a_done)
    );

    block_scan_ctrl #(.IMG_W_BLK(3), .IMG_H_BLK(1), .ADDR_W(12), .BLK_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_abort(s_abort),
        .o_addr(b_addr), .o_addr_valid(b_valid), .i_addr_ready(s_ready),
        .o_blk_idx(b_idx), .o_blk_first(b_first), .o_blk_last(b_last),
        .o_frame_last(b_fl), .o_busy(b_busy), .o_done(b_done)
    );

    // Expected outputs for beat n of a frame of wb x hb tiles, from the beat index alone.
    function automatic logic [23:0] exp_beat(input int n, input int wb, input int hb);
        int t, w, px, py, bc, br, a;
        t  = n / 64;
        w  = n % 64;
        py = w / 8;
        px = w % 8;
        bc = t % wb;
        br = t / wb;
        a  = (8 * br + py) * (8 * wb) + 8 * bc + px;
        return {1'b1, 1'b1, (w == 0), (w == 63), (n == 64 * wb * hb - 1), 1'b0,
                6'(t), 12'(a)};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] obs_sel(input logic sel);
        return sel ? obs_b : obs_a;
    endfunction

    // One frame from a start pulse; called and returns at a falling edge.
    task automatic run_frame(input logic sel, input int wb, input int hb, input int rdy_pct,
                             input int stall_beat, input int abort_beat, input bit extra_start);
        int  total = 64 * wb * hb;
        int  n = 0;
        int  guard = 0;
        int  stall_cnt = 0;
        bit  rdy, ab;
        bit  aborted = 1'b0;
        s_sel   = sel;
        s_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s_start = 1'b0;
        while (n < total && guard < 20000) begin
            check("beat", obs_sel(sel), exp_beat(n, wb, hb));
            if (n == stall_beat && stall_cnt < 3) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
            end
            ab      = (n == abort_beat) && rdy;
            s_ready = rdy;
            s_abort = ab;
            s_start = extra_start && (n == 40);
            @(posedge clk); @(negedge clk);
            s_abort = 1'b0;
            s_start = 1'b0;
            guard++;
            if (rdy) n++;
            if (ab) begin
                aborted = 1'b1;
                break;
            end
        end
        s_ready = 1'b1;
        if (guard >= 20000) begin
            n_checks++;
            n_err++;
            $error("FAIL frame_timeout observed=%0d expected=%0d", n, total);
        end else if (aborted) begin
            repeat (3) begin
                check("after_abort", obs_sel(sel) & IDLE_MASK, IDLE_EXP);
                @(posedge clk); @(negedge clk);
            end
        end else begin
            check("done_state", obs_sel(sel) & IDLE_MASK, IDLE_EXP);
            s_start = extra_start;
            @(posedge clk); @(negedge clk);
            s_start = 1'b0;
            check("done_pulse", obs_sel(sel) & IDLE_MASK, DONE_EXP);
            @(posedge clk); @(negedge clk);
            check("after_done", obs_sel(sel) & IDLE_MASK, IDLE_EXP);
            @(posedge clk); @(negedge clk);
            check("idle_hold", obs_sel(sel) & IDLE_MASK, IDLE_EXP);
        end
    endtask

    initial begin
        rst     = 1'b0;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_ready = 1'b1;
        s_sel   = 1'b0;
        #12;
        check("reset_a", obs_a, 24'h0);
        check("reset_b", obs_b, 24'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("idle_after_reset", obs_a & IDLE_MASK, IDLE_EXP);

        // Full frame, ready held high.
        run_frame(1'b0, 2, 2, 100, -1, -1, 1'b0);
        // Three-cycle stall on beat 5.
        run_frame(1'b0, 2, 2, 100, 5, -1, 1'b0);
        // Extra start mid-frame and during DONE.
        run_frame(1'b0, 2, 2, 100, -1, -1, 1'b1);
        // Abort at beat 100, then a fresh frame from address 0.
        run_frame(1'b0, 2, 2, 100, -1, 100, 1'b0);
        run_frame(1'b0, 2, 2, 100, -1, -1, 1'b0);

        // Abort and start together in IDLE: stays idle.
        s_sel = 1'b0; s_start = 1'b1; s_abort = 1'b1;
        @(posedge clk); @(negedge clk);
        s_start = 1'b0; s_abort = 1'b0;
        check("abort_start_idle", obs_a & IDLE_MASK, IDLE_EXP);
        @(posedge clk); @(negedge clk);
        check("abort_start_idle2", obs_a & IDLE_MASK, IDLE_EXP);

        // Random backpressure, with and without a random abort.
        run_frame(1'b0, 2, 2, 60, -1, -1, 1'b0);
        run_frame(1'b0, 2, 2, 70, $urandom_range(10, 255), $urandom_range(0, 255), 1'b0);
        run_frame(1'b0, 2, 2, 40, -1, -1, 1'b1);

        // Non-power-of-two tile width.
        run_frame(1'b1, 3, 1, 100, -1, -1, 1'b0);
        run_frame(1'b1, 3, 1, 50, 17, -1, 1'b0);

        // Asynchronous reset in the middle of a frame.
        s_sel = 1'b0; s_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s_start = 1'b0; s_ready = 1'b1;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset_mid", obs_a, 24'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("post_reset_idle", obs_a & IDLE_MASK, IDLE_EXP);
        end
        run_frame(1'b0, 2, 2, 100, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
